uart_tx_arb: RTL

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_rr_pick.sv | 42 ++++
 rtl/uart_tx_arb.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and byte width.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: returns the first requester at or after ptr_i,
// wrapping modulo NUM_REQ, as a one-hot grant plus an any-request flag.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               any_o
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] k;
    logic [PTR_W-1:0] pick;

    always_comb begin
        any_o   = 1'b0;
        pick    = '0;
        sum     = '0;
        k       = '0;
        grant_o = '0;
        // Walk from the farthest offset down so the nearest valid requester wins.
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            sum = {1'b0, ptr_i} + (PTR_W + 1)'(j);
            if (sum >= (PTR_W + 1)'(NUM_REQ)) begin
                sum = sum - (PTR_W + 1)'(NUM_REQ);
            end
            k = sum[PTR_W-1:0];
            if (req_i[k]) begin
                pick  = k;
                any_o = 1'b1;
            end
        end
        if (any_o) begin
            grant_o[pick] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-locking round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams.
// Optional watchdog release of a stalled lock is enabled by defining UART_ARB_TIMEOUT_EN.
//
//   state  | meaning
//   S_IDLE | no owner; pick next requester round-robin from rr_ptr
//   S_LOCK | granted requester owns the transmitter until its last byte
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           clk,
    input  logic                           i_rst,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]             i_req_last,
    output logic [NUM_REQ-1:0]             o_req_ready,
    output logic                           o_tx_valid,
    output logic [UART_BYTE_W-1:0]         o_tx_data,
    input  logic                           i_tx_ready,
    output logic [NUM_REQ-1:0]             o_grant,
    output logic                           o_timeout
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   gidx_q, gidx_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   gidx_next;
    logic [PTR_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_grant;
    logic               pick_any;
    logic               locked;
    logic               xfer;

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] wdog_q, wdog_d;
    logic       timeout_q, timeout_d;
`endif

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req_i   (i_req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .any_o   (pick_any)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                pick_idx = PTR_W'(i);
            end
        end
    end

    // Reset gates the datapath so nothing can transfer in the reset cycle.
    assign locked      = (state_q == S_LOCK) && !i_rst;
    assign o_tx_valid  = locked && i_req_valid[gidx_q];
    assign o_tx_data   = locked ? i_req_data[gidx_q*UART_BYTE_W +: UART_BYTE_W] : '0;
    assign o_req_ready = locked ? (grant_q & {NUM_REQ{i_tx_ready}}) : '0;
    assign xfer        = o_tx_valid && i_tx_ready;
    assign o_grant     = grant_q;
    assign gidx_next   = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
`ifdef UART_ARB_TIMEOUT_EN
        wdog_d    = wdog_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    state_d = S_LOCK;
                    grant_d = pick_grant;
                    gidx_d  = pick_idx;
`ifdef UART_ARB_TIMEOUT_EN
                    wdog_d  = '0;
`endif
                end
            end
            S_LOCK: begin
                if (xfer) begin
`ifdef UART_ARB_TIMEOUT_EN
                    wdog_d = '0;
`endif
                    if (i_req_last[gidx_q]) begin
                        state_d  = S_IDLE;
                        grant_d  = '0;
                        rr_ptr_d = gidx_next;
                    end
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (wdog_q + 8'd1 == WDOG_LIMIT) begin
                    state_d   = S_IDLE;
                    grant_d   = '0;
                    rr_ptr_d  = gidx_next;
                    wdog_d    = '0;
                    timeout_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            rr_ptr_q  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            wdog_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            rr_ptr_q  <= rr_ptr_d;
`ifdef UART_ARB_TIMEOUT_EN
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
`endif
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

endmodule
